wb_cmd_master: RTL and testbench

- Wishbone classic single-transfer initiator that turns a valid/ready command stream into Wishbone cycles toward peripheral slaves such as the system controller.
- Returns read data and status on a valid/ready response stream.
- Only one transaction is outstanding at a time.
- A bus timeout guarantees forward progress when a slave never acknowledges.

---
 rtl/wb_pkg.sv | 34 +++
 rtl/wb_timeout_cnt.sv | 45 ++++
 rtl/wb_cmd_master.sv | 148 ++++++++++++++
 tb/tb_wb_cmd_master.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and constants for the Wishbone command master.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Command payload captured at acceptance (address kept separately
    // because its width is a module parameter).
    typedef struct packed {
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
        logic             we;
    } cmd_t;

    // Response payload presented on the response stream.
    typedef struct packed {
        logic [WB_DW-1:0] dat;
        logic             err;
        logic             tmo;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : wb_timeout_cnt
//  Description : Bus-cycle counter with clear and enable; flags expiry when
//                the count reaches TIMEOUT-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_cnt #(
    parameter int TIMEOUT = 255,
    parameter int TOW     = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TOW-1:0] cnt_q;
    logic [TOW-1:0] cnt_d;

    // Clear has priority; otherwise count up while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TOW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The master leaves BUS on the expiry cycle, so the counter never wraps.
    assign expired_o = (cnt_q == TOW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : wb_cmd_master
//  Description : Wishbone classic single-transfer initiator. Converts a
//                valid/ready command stream into Wishbone cycles and returns
//                read data / status on a valid/ready response stream, with a
//                bus timeout for slaves that never respond.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_cmd_master
    import wb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TOW     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    // command stream
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [AW-1:0]     i_cmd_adr,
    input  logic [WB_DW-1:0]  i_cmd_dat,
    input  logic [WB_SW-1:0]  i_cmd_sel,
    input  logic              i_cmd_we,
    // response stream
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [WB_DW-1:0]  o_rsp_dat,
    output logic              o_rsp_err,
    output logic              o_rsp_tmo,
    // Wishbone initiator
    output logic [AW-1:0]     o_wb_adr,
    output logic [WB_DW-1:0]  o_wb_dat,
    output logic [WB_SW-1:0]  o_wb_sel,
    output logic              o_wb_we,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    input  logic [WB_DW-1:0]  i_wb_rdt,
    input  logic              i_wb_ack,
    input  logic              i_wb_err
);

    state_e           state_q, state_d;
    logic [AW-1:0]    adr_q,   adr_d;
    cmd_t             cmd_q,   cmd_d;
    logic             cyc_q,   cyc_d;
    rsp_t             rsp_q,   rsp_d;

    logic             w_accept;
    logic             w_expired;

    assign w_accept = (state_q == IDLE) && i_cmd_valid;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TOW     (TOW)
    ) u_tmo (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .clr_i     (w_accept),
        .en_i      (state_q == BUS),
        .expired_o (w_expired)
    );

    // Next-state and datapath: err beats ack, ack beats timeout.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cmd_d   = cmd_q;
        cyc_d   = cyc_q;
        rsp_d   = rsp_q;
        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    adr_d     = i_cmd_adr;
                    cmd_d.dat = i_cmd_dat;
                    cmd_d.sel = i_cmd_sel;
                    cmd_d.we  = i_cmd_we;
                    cyc_d     = 1'b1;
                    state_d   = BUS;
                end
            end
            BUS: begin
                if (i_wb_err) begin
                    cyc_d     = 1'b0;
                    rsp_d     = '0;
                    rsp_d.err = 1'b1;
                    state_d   = RESP;
                end else if (i_wb_ack) begin
                    cyc_d     = 1'b0;
                    rsp_d     = '0;
                    rsp_d.dat = cmd_q.we ? '0 : i_wb_rdt;
                    state_d   = RESP;
                end else if (w_expired) begin
                    cyc_d     = 1'b0;
                    rsp_d     = '0;
                    rsp_d.err = 1'b1;
                    rsp_d.tmo = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset drops cyc/stb immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            cmd_q   <= '0;
            cyc_q   <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cmd_q   <= cmd_d;
            cyc_q   <= cyc_d;
            rsp_q   <= rsp_d;
        end
    end

    // Handshake flags decode from registered state only, so there is no
    // combinational path from i_rsp_ready to o_cmd_ready.
    assign o_cmd_ready = (state_q == IDLE);
    assign o_rsp_valid = (state_q == RESP);
    assign o_rsp_dat   = rsp_q.dat;
    assign o_rsp_err   = rsp_q.err;
    assign o_rsp_tmo   = rsp_q.tmo;

    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = cmd_q.dat;
    assign o_wb_sel    = cmd_q.sel;
    assign o_wb_we     = cmd_q.we;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_cmd_master
//  Description : Self-checking bench for wb_cmd_master with a slave model and
//                a transaction-level reference for expected responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

    localparam int AW_P      = 32;
    localparam int TIMEOUT_P = 8;
    localparam int TOW_P     = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_cmd_valid = 1'b0;
    logic              o_cmd_ready;
    logic [AW_P-1:0]   i_cmd_adr = '0;
    logic [31:0]       i_cmd_dat = '0;
    logic [3:0]        i_cmd_sel = '0;
    logic              i_cmd_we = 1'b0;
    logic              o_rsp_valid;
    logic              i_rsp_ready = 1'b0;
    logic [31:0]       o_rsp_dat;
    logic              o_rsp_err;
    logic              o_rsp_tmo;
    logic [AW_P-1:0]   o_wb_adr;
    logic [31:0]       o_wb_dat;
    logic [3:0]        o_wb_sel;
    logic              o_wb_we;
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic [31:0]       i_wb_rdt = '0;
    logic              i_wb_ack = 1'b0;
    logic              i_wb_err = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    wb_cmd_master #(
        .AW      (AW_P),
        .TIMEOUT (TIMEOUT_P),
        .TOW     (TOW_P)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_adr   (i_cmd_adr),
        .i_cmd_dat   (i_cmd_dat),
        .i_cmd_sel   (i_cmd_sel),
        .i_cmd_we    (i_cmd_we),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_dat   (o_rsp_dat),
        .o_rsp_err   (o_rsp_err),
        .o_rsp_tmo   (o_rsp_tmo),
        .o_wb_adr    (o_wb_adr),
        .o_wb_dat    (o_wb_dat),
        .o_wb_sel    (o_wb_sel),
        .o_wb_we     (o_wb_we),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .i_wb_rdt    (i_wb_rdt),
        .i_wb_ack    (i_wb_ack),
        .i_wb_err    (i_wb_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    // One full transaction. The slave responds in BUS cycle 'delay'
    // (1-based); a delay beyond TIMEOUT means it never responds.
    // use_err drives err; both additionally drives ack in the same cycle.
    task automatic run_txn(input string name, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, input int delay, input logic use_err,
                           input logic both, input logic [31:0] rdt,
                           input int rdly);
        int          k;
        bit          done;
        int          exp_cycles;
        logic        exp_tmo, exp_err;
        logic [31:0] exp_dat;

        exp_tmo    = (delay > TIMEOUT_P);
        exp_cycles = exp_tmo ? TIMEOUT_P : delay;
        exp_err    = exp_tmo || use_err;
        exp_dat    = (exp_err || we) ? 32'h0 : rdt;

        n_cmp++;
        if (o_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: got %b want 1", name, o_cmd_ready);
        end

        i_cmd_valid = 1'b1;
        i_cmd_adr   = adr;
        i_cmd_dat   = dat;
        i_cmd_sel   = sel;
        i_cmd_we    = we;
        step();
        i_cmd_valid = 1'b0;
        i_cmd_adr   = $urandom;
        i_cmd_dat   = $urandom;
        i_cmd_sel   = 4'($urandom);
        i_cmd_we    = 1'($urandom);

        k    = 1;
        done = 1'b0;
        while (!done) begin
            n_cmp++;
            if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b1 || o_cmd_ready !== 1'b0 ||
                o_rsp_valid !== 1'b0 || o_wb_adr !== adr || o_wb_dat !== dat ||
                o_wb_sel !== sel || o_wb_we !== we) begin
                n_fail++;
                $display("FAIL %s bus_cycle%0d: got cyc=%b stb=%b rdy=%b rv=%b adr=%h dat=%h sel=%h we=%b want 1 1 0 0 %h %h %h %b",
                         name, k, o_wb_cyc, o_wb_stb, o_cmd_ready, o_rsp_valid,
                         o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, adr, dat, sel, we);
            end
            if (k == delay) begin
                i_wb_err = use_err;
                i_wb_ack = !use_err || both;
                i_wb_rdt = rdt;
            end else begin
                i_wb_rdt = $urandom;
            end
            step();
            i_wb_ack = 1'b0;
            i_wb_err = 1'b0;
            if (!o_wb_cyc) begin
                done = 1'b1;
            end else if (k >= TIMEOUT_P + 4) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s cycle_bound: got cyc still high after %0d want drop", name, k);
                done = 1'b1;
            end else begin
                k++;
            end
        end

        n_cmp++;
        if (k !== exp_cycles) begin
            n_fail++;
            $display("FAIL %s cyc_len: got %0d want %0d", name, k, exp_cycles);
        end

        for (int w = 0; w <= rdly; w++) begin
            n_cmp++;
            if (o_rsp_valid !== 1'b1 || o_rsp_dat !== exp_dat || o_rsp_err !== exp_err ||
                o_rsp_tmo !== exp_tmo || o_cmd_ready !== 1'b0 || o_wb_cyc !== 1'b0 ||
                o_wb_stb !== 1'b0) begin
                n_fail++;
                $display("FAIL %s rsp_w%0d: got rv=%b dat=%h err=%b tmo=%b rdy=%b cyc=%b want 1 %h %b %b 0 0",
                         name, w, o_rsp_valid, o_rsp_dat, o_rsp_err, o_rsp_tmo,
                         o_cmd_ready, o_wb_cyc, exp_dat, exp_err, exp_tmo);
            end
            if (w < rdly) begin
                // A pending command must not be taken while the response waits.
                i_cmd_valid = 1'b1;
                step();
            end
        end
        i_cmd_valid = 1'b0;
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready = 1'b0;
        n_cmp++;
        if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_hs: got rv=%b rdy=%b cyc=%b want 0 1 0",
                     name, o_rsp_valid, o_cmd_ready, o_wb_cyc);
        end
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rsp_dat !== 32'h0 ||
            o_rsp_err !== 1'b0 || o_rsp_tmo !== 1'b0 || o_wb_cyc !== 1'b0 ||
            o_wb_stb !== 1'b0 || o_wb_we !== 1'b0 || o_wb_adr !== '0 ||
            o_wb_dat !== 32'h0 || o_wb_sel !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_vals: got rdy=%b rv=%b dat=%h err=%b tmo=%b cyc=%b stb=%b we=%b adr=%h wdat=%h sel=%h want 1 0 0 0 0 0 0 0 0 0 0",
                     o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_err, o_rsp_tmo,
                     o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel);
        end
        i_rst_n = 1'b1;
        step();
        // Stray ack/err while idle must be ignored.
        i_wb_ack = 1'b1;
        i_wb_err = 1'b1;
        repeat (2) step();
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        step();
        n_cmp++;
        if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack: got rv=%b rdy=%b cyc=%b want 0 1 0",
                     o_rsp_valid, o_cmd_ready, o_wb_cyc);
        end
    endtask

    task automatic test_read;
        run_txn("read", 32'h0000_0010, 32'h0, 4'hF, 1'b0, 2, 1'b0, 1'b0, 32'hCAFE_F00D, 0);
        run_txn("read_min", 32'h0000_0014, 32'h0, 4'h3, 1'b0, 1, 1'b0, 1'b0, 32'h1357_9BDF, 0);
    endtask

    task automatic test_write;
        run_txn("write", 32'h0000_0008, 32'h1234_5678, 4'hF, 1'b1, 3, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);
    endtask

    task automatic test_timeout;
        run_txn("timeout", 32'h0000_0100, 32'h0, 4'hF, 1'b0, 1000, 1'b0, 1'b0, 32'h0, 0);
        run_txn("ack_at_limit", 32'h0000_0104, 32'h0, 4'hF, 1'b0, TIMEOUT_P, 1'b0, 1'b0, 32'hA5A5_5A5A, 0);
    endtask

    task automatic test_err_priority;
        run_txn("err_both", 32'h0000_0020, 32'h0, 4'hF, 1'b0, 2, 1'b1, 1'b1, 32'hFFFF_FFFF, 0);
        run_txn("err_only", 32'h0000_0024, 32'h55AA_55AA, 4'h1, 1'b1, 1, 1'b1, 1'b0, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_backpressure;
        run_txn("backpressure", 32'h0000_0030, 32'h0, 4'hF, 1'b0, 2, 1'b0, 1'b0, 32'h0BAD_F00D, 5);
    endtask

    task automatic test_reset_mid_bus;
        i_cmd_valid = 1'b1;
        i_cmd_adr   = 32'h0000_0040;
        i_cmd_we    = 1'b0;
        step();
        i_cmd_valid = 1'b0;
        step();
        #2;
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_bus: got cyc=%b stb=%b rv=%b want 0 0 0",
                     o_wb_cyc, o_wb_stb, o_rsp_valid);
        end
        step();
        i_rst_n = 1'b1;
        i_wb_ack = 1'b1;
        step();
        i_wb_ack = 1'b0;
        n_cmp++;
        if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_discard: got rv=%b rdy=%b want 0 1", o_rsp_valid, o_cmd_ready);
        end
        run_txn("after_reset", 32'h0000_0044, 32'h0, 4'hF, 1'b0, 2, 1'b0, 1'b0, 32'h600D_600D, 0);
    endtask

    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            logic ue;
            ue = ($urandom_range(0, 3) == 0);
            run_txn("random", $urandom, $urandom, 4'($urandom), 1'($urandom),
                    int'($urandom_range(1, TIMEOUT_P + 2)), ue, ue && 1'($urandom),
                    $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_err_priority();
        test_backpressure();
        test_reset_mid_bus();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
